axi_lite_slave_bridge: RTL
==========================

Name: axi_lite_slave_bridge

Overview:
AXI4-lite slave that terminates the bus driven by the CPU-side AXI4-lite master and converts each transaction into a single-beat access on a simple peripheral/memory port.
- Captures AW and W in either order, then issues one peripheral write; issues one peripheral read per AR.
- Returns BRESP/RRESP.
- Decodes an address window; out-of-window accesses get SLVERR without touching the peripheral.
- One outstanding transaction at a time.

Parameters:
- ADDR_BASE, 32'h0000_0000, first byte address of the decoded window
- ADDR_SIZE, 32'h0001_0000, window size in bytes; in-window when ADDR_BASE <= addr < ADDR_BASE+ADDR_SIZE
- TIMEOUT_CYCLES, 16, peripheral wait limit (used only with the optional feature); must be >= 1

Ports:
- ACLK  in  1  AXI clock
- ARESETn  in  1  AXI reset
- AWVALID  in  1  write address valid
- AWREADY  out  1  write address ready
- AWADDR  in  AXI_ADDR_WIDTH  write address
- AWPROT  in  3  ignored
- WVALID  in  1  write data valid
- WREADY  out  1  write data ready
- WDATA  in  AXI_DATA_WIDTH  write data
- WSTRB  in  AXI_STRB_WIDTH  byte strobes
- BVALID  out  1  write response valid
- BREADY  in  1  write response ready
- BRESP  out  2  write response
- ARVALID  in  1  read address valid
- ARREADY  out  1  read address ready
- ARADDR  in  AXI_ADDR_WIDTH  read address
- ARPROT  in  3  ignored
- RVALID  out  1  read data valid
- RREADY  in  1  read data ready
- RDATA  out  AXI_DATA_WIDTH  read data
- RRESP  out  2  read response
- P_access  out  1  peripheral access request
- P_rd0_wr1  out  1  0 = read, 1 = write
- P_addr  out  AXI_ADDR_WIDTH  access address, offset from ADDR_BASE
- P_write_data  out  AXI_DATA_WIDTH  write data
- P_write_strobe  out  AXI_STRB_WIDTH  byte strobes
- P_ready  in  1  access complete this cycle
- P_read_data  in  AXI_DATA_WIDTH  read data, valid when P_ready is high
- P_error  in  1  sampled with P_ready; 1 means SLVERR

Behaviour:
- Clock and reset: clock ACLK; reset ARESETn, asynchronous, active-low. All logic is in the ACLK domain.
- Reset values: all outputs 0; state IDLE; capture flags cleared.
- States: IDLE, WCAP, WACC, BRSP, RACC, RRSP.

Handshake ready signals (combinational from state and flags):
- AWREADY = 1 in IDLE, or in WCAP when AW has not yet been captured.
- WREADY = 1 in IDLE, or in WCAP when W has not yet been captured.
- ARREADY = 1 only in IDLE when AWVALID = 0 and WVALID = 0. Write has priority over read.

Transitions:
- IDLE:
  - AW and W both handshake -> WACC.
  - Only one of them handshakes -> WCAP.
  - AR handshakes -> RACC.
- WCAP: remaining AW or W handshakes -> WACC.
- WACC:
  - Address in window: P_access = 1 and P_rd0_wr1 = 1, held until P_ready is sampled high, then -> BRSP.
  - Address out of window: no P_access; -> BRSP on the next cycle with SLVERR.
- BRSP: BVALID = 1 until BREADY is sampled, then -> IDLE.
- RACC: same as WACC with P_rd0_wr1 = 0. P_read_data is registered into RDATA when P_ready is high; -> RRSP.
- RRSP: RVALID = 1 until RREADY is sampled, then -> IDLE.

Response and output rules:
- BVALID, RVALID, BRESP, RRESP and RDATA are registered and held stable while waiting for the handshake.
- RESP encoding: 2'b00 OKAY; 2'b10 SLVERR on P_error or decode miss.
- Out-of-window read returns RDATA = 0.
- P_access deasserts in the cycle after P_ready is sampled; it never stays high for two accesses back to back.
- P_addr = addr - ADDR_BASE. Subtraction is AXI_ADDR_WIDTH wide; no wrap occurs inside the window.
- Minimum latency: AR handshake at cycle 0 -> P_access at cycle 1 -> with P_ready at cycle 1, RVALID at cycle 2.
- Reset asserted mid-transaction: all state is dropped immediately and P_access = 0. No response is issued after reset.

Optional Feature:
Macro: AXI_SLV_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WACC or RACC and increments each cycle P_access = 1 and P_ready = 0.
  - When it reaches TIMEOUT_CYCLES, the block drops P_access, responds SLVERR (RDATA = 0 for reads) and moves to BRSP or RRSP.
  - A late P_ready after that point is ignored.
- Not defined: no counter; the block waits on P_ready indefinitely.

Test Plan:
- Write 0x0000_0010 data 0xDEADBEEF WSTRB 4'hF, AW and W in the same cycle, P_ready 1 cycle after P_access -> P_addr = 0x10, P_write_data = 0xDEADBEEF, BRESP = 00.
- W presented 3 cycles before AW -> WREADY handshake first, stays in WCAP, single P_access after AW, BRESP = 00.
- Read 0x0000_0020, P_read_data = 0x12345678, BREADY/RREADY low for 4 cycles -> RVALID and RDATA stable for 4 cycles, then RDATA = 0x12345678, RRESP = 00.
- Read 0x0002_0000 (out of window) -> P_access never asserted, RRESP = 10, RDATA = 0.
- AWVALID, WVALID and ARVALID asserted together -> write completes first; ARREADY only after returning to IDLE.
- With AXI_SLV_TIMEOUT_EN and TIMEOUT_CYCLES = 16, P_ready tied low -> P_access drops after 16 cycles, BRESP = 10; without the macro, the block remains in WACC.

Source files
------------

// File: rtl/axi_lite_slave_bridge_if.sv
// AXI4-lite bus bundle between the CPU-side master and axi_lite_slave_bridge.
interface axi_lite_slave_bridge_if #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
);
  logic                      AWVALID, AWREADY;
  logic [AXI_ADDR_WIDTH-1:0] AWADDR;
  logic [2:0]                AWPROT;
  logic                      WVALID, WREADY;
  logic [AXI_DATA_WIDTH-1:0] WDATA;
  logic [AXI_STRB_WIDTH-1:0] WSTRB;
  logic                      BVALID, BREADY;
  logic [1:0]                BRESP;
  logic                      ARVALID, ARREADY;
  logic [AXI_ADDR_WIDTH-1:0] ARADDR;
  logic [2:0]                ARPROT;
  logic                      RVALID, RREADY;
  logic [AXI_DATA_WIDTH-1:0] RDATA;
  logic [1:0]                RRESP;

  modport slave (
    input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
           ARVALID, ARADDR, ARPROT, RREADY,
    output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );
  modport master (
    output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
           ARVALID, ARADDR, ARPROT, RREADY,
    input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );
endinterface

// File: rtl/axi_lite_slave_bridge.sv
// AXI4-lite slave -> single-beat peripheral port, one transaction in flight.
// Optional peripheral timeout enabled by defining AXI_SLV_TIMEOUT_EN.
module axi_lite_slave_bridge #(
  parameter int                      AXI_ADDR_WIDTH = 32,
  parameter int                      AXI_DATA_WIDTH = 32,
  parameter int                      AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
  parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_BASE    = 32'h0000_0000,
  parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_SIZE    = 32'h0001_0000,
  parameter int                      TIMEOUT_CYCLES = 16
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  axi_lite_slave_bridge_if.slave    s_axi,
  output logic                      P_access,
  output logic                      P_rd0_wr1,
  output logic [AXI_ADDR_WIDTH-1:0] P_addr,
  output logic [AXI_DATA_WIDTH-1:0] P_write_data,
  output logic [AXI_STRB_WIDTH-1:0] P_write_strobe,
  input  logic                      P_ready,
  input  logic [AXI_DATA_WIDTH-1:0] P_read_data,
  input  logic                      P_error
);
  localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, WCAP, WACC, BRSP, RACC, RRSP} state_e;

  state_e                    state_q, state_d;
  logic                      aw_got_q, aw_got_d, w_got_q, w_got_d, hit_q, hit_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [AXI_STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                      bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]                bresp_q, bresp_d, rresp_q, rresp_d;
  logic                      aw_hs, w_hs, ar_hs, acc_done, acc_err;
  logic [AXI_DATA_WIDTH-1:0] acc_data;

`ifdef AXI_SLV_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  logic unused_prot;
  assign unused_prot = ^{s_axi.AWPROT, s_axi.ARPROT};

  // Subtract first so the window top never overflows the address width.
  function automatic logic in_window(input logic [AXI_ADDR_WIDTH-1:0] a);
    return (a >= ADDR_BASE) && ((a - ADDR_BASE) < ADDR_SIZE);
  endfunction

  // Readies are held low during reset so nothing is accepted mid-reset.
  assign s_axi.AWREADY = ARESETn && (state_q == IDLE || (state_q == WCAP && !aw_got_q));
  assign s_axi.WREADY  = ARESETn && (state_q == IDLE || (state_q == WCAP && !w_got_q));
  assign s_axi.ARREADY = ARESETn && state_q == IDLE && !s_axi.AWVALID && !s_axi.WVALID;
  assign aw_hs = s_axi.AWVALID && s_axi.AWREADY;
  assign w_hs  = s_axi.WVALID  && s_axi.WREADY;
  assign ar_hs = s_axi.ARVALID && s_axi.ARREADY;

  assign s_axi.BVALID = bvalid_q;
  assign s_axi.BRESP  = bresp_q;
  assign s_axi.RVALID = rvalid_q;
  assign s_axi.RRESP  = rresp_q;
  assign s_axi.RDATA  = rdata_q;

  assign P_access       = hit_q && (state_q == WACC || state_q == RACC);
  assign P_rd0_wr1      = (state_q == WACC);
  assign P_addr         = addr_q;
  assign P_write_data   = wdata_q;
  assign P_write_strobe = wstrb_q;

  always_comb begin
    state_d  = state_q;
    aw_got_d = aw_got_q;
    w_got_d  = w_got_q;
    hit_d    = hit_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    acc_done = 1'b0;
    acc_err  = 1'b0;
    acc_data = '0;
`ifdef AXI_SLV_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    if (state_q == IDLE || state_q == WCAP) begin
      if (aw_hs) begin
        addr_d = s_axi.AWADDR - ADDR_BASE;
        hit_d  = in_window(s_axi.AWADDR);
      end
      if (w_hs) begin
        wdata_d = s_axi.WDATA;
        wstrb_d = s_axi.WSTRB;
      end
    end
    case (state_q)
      IDLE: begin
        if (aw_hs && w_hs) state_d = WACC;
        else if (aw_hs || w_hs) begin
          state_d  = WCAP;
          aw_got_d = aw_hs;
          w_got_d  = w_hs;
        end else if (ar_hs) begin
          state_d = RACC;
          addr_d  = s_axi.ARADDR - ADDR_BASE;
          hit_d   = in_window(s_axi.ARADDR);
        end
      end
      WCAP: begin
        if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
          state_d  = WACC;
          aw_got_d = 1'b0;
          w_got_d  = 1'b0;
        end
      end
      WACC, RACC: begin
        acc_done = !hit_q || P_ready;
        acc_err  = !hit_q || P_error;
        acc_data = hit_q ? P_read_data : '0;
`ifdef AXI_SLV_TIMEOUT_EN
        if (hit_q && !P_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            acc_done = 1'b1;
            acc_err  = 1'b1;
            acc_data = '0;
          end
        end
`endif
        if (acc_done && state_q == WACC) begin
          state_d  = BRSP;
          bvalid_d = 1'b1;
          bresp_d  = acc_err ? RESP_SLVERR : RESP_OKAY;
        end else if (acc_done) begin
          state_d  = RRSP;
          rvalid_d = 1'b1;
          rresp_d  = acc_err ? RESP_SLVERR : RESP_OKAY;
          rdata_d  = acc_data;
        end
      end
      BRSP: if (s_axi.BREADY) begin
        state_d  = IDLE;
        bvalid_d = 1'b0;
      end
      RRSP: if (s_axi.RREADY) begin
        state_d  = IDLE;
        rvalid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
`ifdef AXI_SLV_TIMEOUT_EN
    if ((state_d == WACC || state_d == RACC) && state_d != state_q) cnt_d = '0;
`endif
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q  <= IDLE;
      aw_got_q <= 1'b0;
      w_got_q  <= 1'b0;
      hit_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
`ifdef AXI_SLV_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      aw_got_q <= aw_got_d;
      w_got_q  <= w_got_d;
      hit_q    <= hit_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
`ifdef AXI_SLV_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end
endmodule
